// File: rtl/piece_redraw_seq.sv
// Erases the previous falling piece and draws the current one through a single-request cell painter.
// Optional macro BOARD_CLEAR_EN: paint the whole board with bg_color after reset before the first frame.
module piece_redraw_seq #(
   parameter int CELLS     = 4,
   parameter int GRID_W    = 10,
   parameter int GRID_H    = 20,
   parameter int CELL_PX_W = 64,
   parameter int CELL_PX_H = 24,
   parameter int CW        = 9
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 redraw,
   input  logic [CELLS*4-1:0]   cur_x,
   input  logic [CELLS*5-1:0]   cur_y,
   input  logic [CW-1:0]        piece_color,
   input  logic [CW-1:0]        bg_color,
   input  logic                 paint_busy,
   input  logic                 paint_done,
   output logic                 paint_start,
   output logic [9:0]           paint_x0,
   output logic [8:0]           paint_y0,
   output logic [CW-1:0]        paint_color,
   output logic                 seq_busy,
   output logic                 frame_done
);
   localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;

`ifdef BOARD_CLEAR_EN
   typedef enum logic [2:0] {IDLE, CLEAR, ERASE, DRAW, WAIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, ERASE, DRAW, WAIT} state_t;
`endif

   state_t               state_q, ret_q;
   logic                 pending_q, prev_valid_q, rel_q;
   logic                 paint_start_q, frame_done_q;
   logic [9:0]           paint_x0_q;
   logic [8:0]           paint_y0_q;
   logic [CW-1:0]        paint_color_q;
   logic [IW-1:0]        idx_q;
   logic [CELLS*4-1:0]   snap_x_q, prev_x_q;
   logic [CELLS*5-1:0]   snap_y_q, prev_y_q;

   function automatic logic [9:0] px_x(input logic [3:0] x);
      logic [31:0] p;
      p = 32'(x) * 32'(CELL_PX_W);
      return p[9:0];
   endfunction

   function automatic logic [8:0] px_y(input logic [4:0] y);
      logic [31:0] p;
      p = 32'(y) * 32'(CELL_PX_H);
      return p[8:0];
   endfunction

   function automatic logic on_board(input logic [3:0] x, input logic [4:0] y);
      return (int'(x) < GRID_W) && (int'(y) < GRID_H);
   endfunction

   function automatic logic in_set(input logic [3:0] x, input logic [4:0] y,
                                   input logic [CELLS*4-1:0] sx, input logic [CELLS*5-1:0] sy);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < CELLS; j++)
         if (sx[4*j +: 4] == x && sy[5*j +: 5] == y) hit = 1'b1;
      return hit;
   endfunction

   // Look-ahead: the next cell worth painting, so a frame never spends a request on a skipped cell.
   logic [CELLS*4-1:0] src_x;
   logic [CELLS*5-1:0] src_y;
   logic               erase_on, e_hit, d_hit, nxt_hit, nxt_erase, in_clear, advance;
   int                 e_from, d_from;
   logic [IW-1:0]      e_idx, d_idx, nxt_idx;
   logic [3:0]         nxt_x;
   logic [4:0]         nxt_y;

   always_comb begin
      src_x    = (state_q == IDLE) ? cur_x : snap_x_q;
      src_y    = (state_q == IDLE) ? cur_y : snap_y_q;
      erase_on = 1'b0;
      e_from   = 0;
      d_from   = 0;
      if (state_q == IDLE) begin
         erase_on = prev_valid_q;
      end else if (state_q == WAIT) begin
         if (ret_q == ERASE) begin
            erase_on = 1'b1;
            e_from   = int'(idx_q) + 1;
         end else begin
            d_from   = int'(idx_q) + 1;
         end
      end
      e_hit = 1'b0;
      e_idx = '0;
      d_hit = 1'b0;
      d_idx = '0;
      for (int i = CELLS - 1; i >= 0; i--) begin
         if (erase_on && i >= e_from && on_board(prev_x_q[4*i +: 4], prev_y_q[5*i +: 5]) &&
             !in_set(prev_x_q[4*i +: 4], prev_y_q[5*i +: 5], src_x, src_y)) begin
            e_hit = 1'b1;
            e_idx = IW'(i);
         end
         if (i >= d_from && on_board(src_x[4*i +: 4], src_y[5*i +: 5])) begin
            d_hit = 1'b1;
            d_idx = IW'(i);
         end
      end
      nxt_hit   = e_hit | d_hit;
      nxt_erase = e_hit;
      nxt_idx   = e_hit ? e_idx : d_idx;
      nxt_x     = e_hit ? prev_x_q[4*nxt_idx +: 4] : src_x[4*nxt_idx +: 4];
      nxt_y     = e_hit ? prev_y_q[5*nxt_idx +: 5] : src_y[5*nxt_idx +: 5];
   end

`ifdef BOARD_CLEAR_EN
   logic [3:0] cx_q, clr_nx;
   logic [4:0] cy_q, clr_ny;
   assign in_clear = (ret_q == CLEAR);
   assign clr_nx   = (int'(cx_q) == GRID_W - 1) ? 4'd0 : cx_q + 4'd1;
   assign clr_ny   = (int'(cx_q) == GRID_W - 1) ? cy_q + 5'd1 : cy_q;
`else
   assign in_clear = 1'b0;
`endif

   assign advance = (state_q == IDLE) ? (redraw | pending_q)
                                      : (state_q == WAIT && paint_done && !in_clear);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= IDLE;
         ret_q         <= IDLE;
         pending_q     <= 1'b0;
         prev_valid_q  <= 1'b0;
         rel_q         <= 1'b1;
         paint_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         paint_x0_q    <= '0;
         paint_y0_q    <= '0;
         paint_color_q <= '0;
         idx_q         <= '0;
`ifdef BOARD_CLEAR_EN
         cx_q          <= '0;
         cy_q          <= '0;
`endif
      end else begin
         paint_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         rel_q         <= 1'b0;
         if (redraw && state_q != IDLE) pending_q <= 1'b1;
         if (rel_q) begin
            pending_q <= 1'b1;
`ifdef BOARD_CLEAR_EN
            cx_q          <= '0;
            cy_q          <= '0;
            paint_x0_q    <= '0;
            paint_y0_q    <= '0;
            paint_color_q <= bg_color;
            ret_q         <= CLEAR;
            state_q       <= CLEAR;
            paint_start_q <= !paint_busy;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  if (advance) begin
                     pending_q <= 1'b0;
                     // NOTE: snapshot/previous cell registers carry no reset; prev_valid_q qualifies them.
                     snap_x_q  <= cur_x;
                     snap_y_q  <= cur_y;
                  end
               end
`ifdef BOARD_CLEAR_EN
               CLEAR,
`endif
               ERASE, DRAW: begin
                  if (paint_start_q) state_q <= WAIT;
                  else               paint_start_q <= !paint_busy;
               end
               WAIT: begin
`ifdef BOARD_CLEAR_EN
                  if (paint_done && in_clear) begin
                     if (int'(cx_q) == GRID_W - 1 && int'(cy_q) == GRID_H - 1) begin
                        state_q <= IDLE;
                     end else begin
                        cx_q          <= clr_nx;
                        cy_q          <= clr_ny;
                        paint_x0_q    <= px_x(clr_nx);
                        paint_y0_q    <= px_y(clr_ny);
                        paint_color_q <= bg_color;
                        state_q       <= CLEAR;
                        paint_start_q <= !paint_busy;
                     end
                  end
`endif
               end
               default: state_q <= IDLE;
            endcase
            if (advance) begin
               if (nxt_hit) begin
                  idx_q         <= nxt_idx;
                  paint_x0_q    <= px_x(nxt_x);
                  paint_y0_q    <= px_y(nxt_y);
                  paint_color_q <= nxt_erase ? bg_color : piece_color;
                  state_q       <= nxt_erase ? ERASE : DRAW;
                  ret_q         <= nxt_erase ? ERASE : DRAW;
                  paint_start_q <= !paint_busy;
               end else begin
                  prev_x_q      <= src_x;
                  prev_y_q      <= src_y;
                  prev_valid_q  <= 1'b1;
                  frame_done_q  <= 1'b1;
                  state_q       <= IDLE;
               end
            end
         end
      end
   end

   assign paint_start = paint_start_q;
   assign paint_x0    = paint_x0_q;
   assign paint_y0    = paint_y0_q;
   assign paint_color = paint_color_q;
   assign frame_done  = frame_done_q;
   assign seq_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_piece_redraw_seq.sv
// Directed bench for piece_redraw_seq: a painter model answers each request three cycles later
// and logs every paint; logs are compared against hand-derived cell lists.
module tb_piece_redraw_seq;
   localparam int CW = 9;

   logic          CLOCK_50 = 1'b0;
   logic          reset = 1'b1;
   logic          redraw = 1'b0;
   logic [15:0]   cur_x = '0;
   logic [19:0]   cur_y = '0;
   logic [CW-1:0] piece_color = 9'h1A5;
   logic [CW-1:0] bg_color = 9'h003;
   logic          paint_busy = 1'b0;
   logic          paint_done = 1'b0;
   logic          paint_start, seq_busy, frame_done;
   logic [9:0]    paint_x0;
   logic [8:0]    paint_y0;
   logic [CW-1:0] paint_color;

   piece_redraw_seq dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .redraw      (redraw),
      .cur_x       (cur_x),
      .cur_y       (cur_y),
      .piece_color (piece_color),
      .bg_color    (bg_color),
      .paint_busy  (paint_busy),
      .paint_done  (paint_done),
      .paint_start (paint_start),
      .paint_x0    (paint_x0),
      .paint_y0    (paint_y0),
      .paint_color (paint_color),
      .seq_busy    (seq_busy),
      .frame_done  (frame_done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_pass = 0;
   int fd_cnt = 0;
   int viol = 0;
   int pcnt = 0;
   logic [27:0] log_q[$];
   logic [27:0] exp_q[$];

   // Painter: busy from the start cycle, done pulse three cycles after start.
   initial begin
      forever begin
         @(negedge CLOCK_50);
         paint_done = 1'b0;
         if (frame_done) fd_cnt++;
         if (pcnt > 0) begin
            if (paint_start) viol++;
            pcnt--;
            if (pcnt == 0) begin
               paint_busy = 1'b0;
               paint_done = 1'b1;
            end
         end else if (paint_start) begin
            log_q.push_back({paint_x0, paint_y0, paint_color});
            pcnt = 3;
            paint_busy = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge CLOCK_50);
      #1;
   endtask

   task automatic set_piece(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input int x3, input int y3);
      cur_x = {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
      cur_y = {5'(y3), 5'(y2), 5'(y1), 5'(y0)};
   endtask

   task automatic expect_cell(input int x, input int y, input bit erase);
      logic [31:0] px, py;
      px = 32'(x * 64);
      py = 32'(y * 24);
      exp_q.push_back({px[9:0], py[8:0], erase ? bg_color : piece_color});
   endtask

   task automatic pulse_redraw();
      redraw = 1'b1;
      step();
      redraw = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int target);
      int n;
      n = 0;
      while (fd_cnt < target && n < 3000) begin
         step();
         n++;
      end
      check(tag, fd_cnt, target);
   endtask

   task automatic wait_paints(input string tag, input int target, input bit need_done);
      int n;
      n = 0;
      while (!(log_q.size() == target && (!need_done || paint_done)) && n < 3000) begin
         step();
         n++;
      end
      if (n >= 3000) check(tag, log_q.size(), target);
   endtask

   task automatic compare_log(input string tag);
      check({tag, " count"}, log_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
         check($sformatf("%s paint%0d", tag, k), log_q[k], exp_q[k]);
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic expect_board_clear();
`ifdef BOARD_CLEAR_EN
      for (int y = 0; y < 20; y++)
         for (int x = 0; x < 10; x++)
            expect_cell(x, y, 1'b1);
`endif
   endtask

   initial begin
      // Reset state
      set_piece(4, 0, 5, 0, 4, 1, 5, 1);
      repeat (3) step();
      check("rst paint_start", paint_start, 0);
      check("rst seq_busy", seq_busy, 0);
      check("rst frame_done", frame_done, 0);
      check("rst paint_x0", paint_x0, 0);
      check("rst paint_y0", paint_y0, 0);
      check("rst paint_color", paint_color, 0);

      // Initial piece drawn without a request
      expect_board_clear();
      expect_cell(4, 0, 0); expect_cell(5, 0, 0); expect_cell(4, 1, 0); expect_cell(5, 1, 0);
      reset = 1'b0;
`ifndef BOARD_CLEAR_EN
      step();
      check("release paint_start", paint_start, 0);
      check("release seq_busy", seq_busy, 0);
      step();
      check("first paint_start", paint_start, 1);
      check("first seq_busy", seq_busy, 1);
      check("first paint_x0", paint_x0, 256);
      check("first paint_y0", paint_y0, 0);
      check("first paint_color", paint_color, piece_color);
`endif
      wait_frames("init frame wait", 1);
      repeat (10) step();
      check("init frames", fd_cnt, 1);
      check("idle seq_busy", seq_busy, 0);
      compare_log("init");

      // Shift right: erase only uncovered cells; a redraw on the completion edge queues one frame
      set_piece(5, 0, 6, 0, 5, 1, 6, 1);
      pulse_redraw();
      expect_cell(4, 0, 1); expect_cell(4, 1, 1);
      expect_cell(5, 0, 0); expect_cell(6, 0, 0); expect_cell(5, 1, 0); expect_cell(6, 1, 0);
      wait_paints("shift last done", 6, 1'b1);
      pulse_redraw();
      check("coincide frame_done", frame_done, 1);
      expect_cell(5, 0, 0); expect_cell(6, 0, 0); expect_cell(5, 1, 0); expect_cell(6, 1, 0);
      wait_frames("shift frame wait", 3);
      repeat (10) step();
      check("shift frames", fd_cnt, 3);
      compare_log("shift");

      // Three redraws during a busy frame coalesce; inputs changed after the snapshot
      set_piece(0, 0, 1, 0, 0, 1, 1, 1);
      pulse_redraw();
      set_piece(7, 2, 8, 2, 7, 3, 8, 3);
      repeat (5) step();
      repeat (3) begin
         pulse_redraw();
         step();
         step();
      end
      check("coalesce seq_busy", seq_busy, 1);
      expect_cell(5, 0, 1); expect_cell(6, 0, 1); expect_cell(5, 1, 1); expect_cell(6, 1, 1);
      expect_cell(0, 0, 0); expect_cell(1, 0, 0); expect_cell(0, 1, 0); expect_cell(1, 1, 0);
      expect_cell(0, 0, 1); expect_cell(1, 0, 1); expect_cell(0, 1, 1); expect_cell(1, 1, 1);
      expect_cell(7, 2, 0); expect_cell(8, 2, 0); expect_cell(7, 3, 0); expect_cell(8, 3, 0);
      wait_frames("coalesce frame wait", 5);
      repeat (60) step();
      check("coalesce frames", fd_cnt, 5);
      compare_log("coalesce");

      // Cell with y=20 is off the board
      set_piece(2, 5, 3, 5, 2, 20, 3, 6);
      pulse_redraw();
      expect_cell(7, 2, 1); expect_cell(8, 2, 1); expect_cell(7, 3, 1); expect_cell(8, 3, 1);
      expect_cell(2, 5, 0); expect_cell(3, 5, 0); expect_cell(3, 6, 0);
      wait_frames("offboard frame wait", 6);
      repeat (10) step();
      check("offboard frames", fd_cnt, 6);
      compare_log("offboard");

      // Reset while a draw request is outstanding; x=12 cell is off the board
      set_piece(0, 19, 9, 19, 0, 18, 12, 0);
      pulse_redraw();
      expect_cell(2, 5, 1); expect_cell(3, 5, 1); expect_cell(3, 6, 1);
      expect_cell(0, 19, 0);
      wait_paints("pre-reset paints", 4, 1'b0);
      step();
      check("wait seq_busy", seq_busy, 1);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("in-reset paint_start %0d", k), paint_start, 0);
      end
      check("in-reset seq_busy", seq_busy, 0);
      check("in-reset paint_color", paint_color, 0);
      compare_log("pre-reset");
      expect_board_clear();
      expect_cell(0, 19, 0); expect_cell(9, 19, 0); expect_cell(0, 18, 0);
      reset = 1'b0;
`ifndef BOARD_CLEAR_EN
      step();
      check("rerelease paint_start", paint_start, 0);
      step();
      check("rerelease first start", paint_start, 1);
      check("rerelease paint_x0", paint_x0, 0);
      check("rerelease paint_y0", paint_y0, 456);
`endif
      wait_frames("post-reset frame wait", 7);
      repeat (10) step();
      check("post-reset frames", fd_cnt, 7);
      compare_log("post-reset");
      check("painter protocol", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/piece_redraw_seq.md
PIECE_REDRAW_SEQ -- requirements
Module: piece_redraw_seq

Interface
REQ-001 SHALL have parameter CELLS, default 4, number of cells per piece redrawn per frame.
REQ-002 SHALL have parameter GRID_W, default 10; GRID_H, default 20; board size in cells.
REQ-003 SHALL have parameters CELL_PX_W, default 64, and CELL_PX_H, default 24; cell pitch in pixels.
REQ-004 SHALL have parameter CW, default 9, colour width.
REQ-005 SHALL have ports: CLOCK_50 in 1, sole clock; reset in 1, synchronous active-high reset.
REQ-006 SHALL have ports: redraw in 1, one-cycle redraw request; cur_x in CELLS*4, packed cell x (cell i at [4i+3:4i]); cur_y in CELLS*5, packed cell y (cell i at [5i+4:5i]).
REQ-007 SHALL have ports: piece_color in CW; bg_color in CW; paint_busy in 1; paint_done in 1, one-cycle painter completion pulse.
REQ-008 SHALL have ports: paint_start out 1; paint_x0 out 10; paint_y0 out 9; paint_color out CW; seq_busy out 1; frame_done out 1, one-cycle pulse at end of each frame.

Function
REQ-009 SHALL implement states IDLE, CLEAR, ERASE, DRAW, WAIT; WAIT returns to the issuing state on paint_done.
REQ-010 SHALL snapshot cur_x/cur_y into a new-cell register on the cycle a frame starts; later input changes do not affect that frame.
REQ-011 SHALL start a frame from IDLE when redraw=1 or pending=1; paint_start for the first cell is asserted on the following cycle.
REQ-012 SHALL, in ERASE, paint each previous cell i (ascending i) with bg_color, skipping any previous cell equal to any snapshot cell.
REQ-013 SHALL, in DRAW, paint every snapshot cell (ascending i) with piece_color, then copy snapshot to previous, set prev_valid=1, pulse frame_done, return to IDLE.
REQ-014 SHALL skip ERASE entirely while prev_valid=0.
REQ-015 SHALL skip, without painting, any cell with x>=GRID_W or y>=GRID_H.
REQ-016 SHALL compute paint_x0=x*CELL_PX_W and paint_y0=y*CELL_PX_H, truncated to 10 and 9 bits.
REQ-017 SHALL assert paint_start for exactly one cycle, only while paint_busy=0, with paint_x0/paint_y0/paint_color stable from that cycle until paint_done.
REQ-018 SHALL keep at most one painter request outstanding; the next paint_start comes no earlier than the cycle after paint_done.
REQ-019 SHALL set pending when redraw=1 outside IDLE; multiple requests coalesce into one; pending clears when its frame starts.
REQ-020 SHALL, if redraw and frame completion coincide, set pending and start the next frame on the cycle after the return to IDLE.
REQ-021 SHALL drive seq_busy=1 in every state except IDLE.
REQ-022 SHALL ignore paint_done while not in WAIT.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, set state IDLE, pending=0, prev_valid=0, paint_start=0, frame_done=0, paint_x0=0, paint_y0=0, paint_color=0, cell indices 0.
REQ-024 SHALL abort any frame or clear in progress on reset, and drive paint_start=0 from the first reset edge.
REQ-025 SHALL set pending=1 on reset release so the current piece is drawn without a request.

Configuration
REQ-026 SHALL, with BOARD_CLEAR_EN defined, enter CLEAR after reset and paint all GRID_W*GRID_H cells row-major (x fastest) with bg_color before servicing pending.
REQ-027 SHALL, with BOARD_CLEAR_EN undefined, omit CLEAR state and counters; reset goes to IDLE directly.

Verification
REQ-028 Reset release, cur=(4,0)(5,0)(4,1)(5,1), painter done 3 cycles after start -> 4 piece_color paints, x0=256/320, y0=0/24, frame_done once.
REQ-029 Shift piece to (5,0)(6,0)(5,1)(6,1) and pulse redraw -> erase only (4,0),(4,1) at bg_color, then 4 draws.
REQ-030 3 redraw pulses during a busy frame -> exactly one extra frame.
REQ-031 Cell y=20 in cur_y -> that cell is never painted; other 3 cells painted; frame_done pulses.
REQ-032 Reset asserted in WAIT of a DRAW -> paint_start never re-asserts for the old frame; new frame after release.
REQ-033 BOARD_CLEAR_EN defined, reset release -> 200 bg paints, last x0=576 y0=456, then initial piece frame.
